// File: rtl/mul_seq.sv
// Sequential 32x32 shift-add multiplier filling HI/LO (signed or unsigned).
// Build option MUL_EARLY_TERM_EN: leave CALC once the remaining multiplier is zero.
module mul_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  sign,
   input  logic [31:0] multiplicand,
   input  logic [31:0] multiplier,
   output logic        busy,
   output logic        done,
   output logic [31:0] multHI,
   output logic [31:0] multLO
);

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   state_t      state, state_n;
   logic [31:0] mcand, mcand_n;
   logic [31:0] mplr, mplr_n;
   logic [4:0]  count, count_n;
   logic [63:0] acc, acc_n;
   logic        neg, neg_n;
   logic        busy_n, done_n;
   logic [31:0] hi_n, lo_n;
   logic [31:0] mag_a, mag_b;
   logic [63:0] addend;
   logic        last;
   logic        unused;

   assign unused = sign[0];

   assign mag_a = (sign[1] & multiplicand[31]) ? -multiplicand : multiplicand;
   assign mag_b = (sign[1] & multiplier[31]) ? -multiplier : multiplier;
   assign addend = {32'd0, mcand} << count;

`ifdef MUL_EARLY_TERM_EN
   assign last = (count == 5'd31) | (mplr[31:1] == 31'd0);
`else
   assign last = (count == 5'd31);
`endif

   always_comb begin
      state_n = state;
      mcand_n = mcand;
      mplr_n  = mplr;
      count_n = count;
      acc_n   = acc;
      neg_n   = neg;
      busy_n  = busy;
      done_n  = 1'b0;
      hi_n    = multHI;
      lo_n    = multLO;
      unique case (state)
         IDLE: begin
            if (start) begin
               mcand_n = mag_a;
               mplr_n  = mag_b;
               neg_n   = sign[1] & (multiplicand[31] ^ multiplier[31]);
               acc_n   = 64'd0;
               count_n = 5'd0;
               busy_n  = 1'b1;
               state_n = CALC;
            end
         end
         CALC: begin
            if (mplr[0]) acc_n = acc + addend;
            mplr_n  = mplr >> 1;
            count_n = count + 5'd1;
            if (last) state_n = FINISH;
         end
         FINISH: begin
            // negating a zero accumulator yields zero, so no negative zero
            {hi_n, lo_n} = neg ? -acc : acc;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         mcand  <= 32'd0;
         mplr   <= 32'd0;
         count  <= 5'd0;
         acc    <= 64'd0;
         neg    <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         multHI <= 32'd0;
         multLO <= 32'd0;
      end else begin
         state  <= state_n;
         mcand  <= mcand_n;
         mplr   <= mplr_n;
         count  <= count_n;
         acc    <= acc_n;
         neg    <= neg_n;
         busy   <= busy_n;
         done   <= done_n;
         multHI <= hi_n;
         multLO <= lo_n;
      end
   end

endmodule
